// File: rtl/abs_diff_recon.sv
// Reconstructs operand b from reference a and a sign/magnitude abs-diff code, buffered in a 2-entry FIFO.
// Optional delivery statistics are enabled by defining ABS_DIFF_RECON_STATS_EN.
module abs_diff_recon #(
    parameter int INPUT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_0,
    input  logic [INPUT_WIDTH:0]   in_1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] res,
    output logic                   err,
    output logic [15:0]            sample_cnt,
    output logic [15:0]            err_cnt
);

    localparam int W = INPUT_WIDTH;

    logic           w_sign;
    logic [W-1:0]   w_mag;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_dec_res;
    logic           w_dec_err;
    logic           w_push;
    logic           w_pop;
    logic [1:0]     w_count_nxt;

    logic [W-1:0]   r_mem_res [0:1];
    logic [1:0]     r_mem_err;
    logic           r_wptr;
    logic           r_rptr;
    logic [1:0]     r_count;
    logic           r_in_ready;
    logic           r_out_valid;

    // Decode the code against a; err flags codes no valid W-bit b could have produced.
    always_comb begin
        w_sign    = in_1[W];
        w_mag     = in_1[W-1:0];
        w_sum     = {1'b0, in_0} + {1'b0, w_mag};
        w_dec_res = {W{1'b0}};
        w_dec_err = 1'b0;
        if (w_sign) begin
            w_dec_res = w_sum[W-1:0];
            w_dec_err = w_sum[W] | (w_mag == {W{1'b0}});
        end else begin
            w_dec_res = in_0 - w_mag;
            w_dec_err = (w_mag > in_0);
        end
    end

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage, pointers and handshake flags (flags track next occupancy so they stay registered).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_res[0] <= {W{1'b0}};
            r_mem_res[1] <= {W{1'b0}};
            r_mem_err    <= 2'b00;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_res[r_wptr] <= w_dec_res;
                r_mem_err[r_wptr] <= w_dec_err;
                r_wptr            <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign res       = r_mem_res[r_rptr];
    assign err       = r_mem_err[r_rptr];

`ifdef ABS_DIFF_RECON_STATS_EN
    logic [15:0] r_sample_cnt;
    logic [15:0] r_err_cnt;

    // Saturating delivery and error counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= 16'h0000;
            r_err_cnt    <= 16'h0000;
        end else begin
            if (w_pop && (r_sample_cnt != 16'hFFFF)) begin
                r_sample_cnt <= r_sample_cnt + 16'd1;
            end
            if (w_pop && err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;
`else
    assign sample_cnt = 16'h0000;
    assign err_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_abs_diff_recon.sv
// Self-checking bench for abs_diff_recon: directed steps plus randomized traffic against a queue model.
module tb_abs_diff_recon;

`ifdef ABS_DIFF_RECON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_0;
    logic [8:0]  in_1;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  res;
    logic        err;
    logic [15:0] sample_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    int q_res[$];
    bit q_err[$];
    int q_b[$];
    int m_samples = 0;
    int m_errs = 0;
    int n_acc = 0;
    int n_del = 0;
    bit rnd_mode = 1'b0;
    int cur_b = 0;

    abs_diff_recon #(.INPUT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_0       (in_0),
        .in_1       (in_1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res        (res),
        .err        (err),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // b = a -/+ magnitude modulo 256; error when no 8-bit b fits the code.
    function automatic void ref_decode(input int a, input int code, output int b, output bit e);
        int mag;
        mag = code % 256;
        if (code >= 256) begin
            b = (a + mag) % 256;
            e = (a + mag > 255) || (mag == 0);
        end else begin
            b = (a - mag + 256) % 256;
            e = (mag > a);
        end
    endfunction

    task automatic drive(input int a, input int code);
        in_0     = a[7:0];
        in_1     = code[8:0];
        in_valid = 1'b1;
    endtask

    task automatic cycle();
        int b;
        bit e;
        check("in_ready", {31'd0, in_ready}, {31'd0, (q_res.size() < 2)});
        check("out_valid", {31'd0, out_valid}, {31'd0, (q_res.size() > 0)});
        check("sample_cnt", {16'd0, sample_cnt}, STATS ? m_samples : 0);
        check("err_cnt", {16'd0, err_cnt}, STATS ? m_errs : 0);
        if (out_valid && out_ready && q_res.size() > 0) begin
            check("res", {24'd0, res}, q_res[0]);
            check("err", {31'd0, err}, {31'd0, q_err[0]});
            if (rnd_mode) begin
                check("res_vs_b", {24'd0, res}, q_b.pop_front());
            end
            if (q_err[0]) m_errs++;
            m_samples++;
            n_del++;
            void'(q_res.pop_front());
            void'(q_err.pop_front());
        end
        if (in_valid && in_ready) begin
            ref_decode(int'(in_0), int'(in_1), b, e);
            q_res.push_back(b);
            q_err.push_back(e);
            if (rnd_mode) q_b.push_back(cur_b);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_res", {24'd0, res}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_sample_cnt", {16'd0, sample_cnt}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        q_res.delete();
        q_err.delete();
        q_b.delete();
        m_samples = 0;
        m_errs = 0;
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_0      = 8'd0;
        in_1      = 9'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_res", {24'd0, res}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_sample_cnt", {16'd0, sample_cnt}, 32'd0);
        check("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;

        // First edge after release accepts; a=100, code=0x00A -> 90.
        out_ready = 1'b1;
        drive(100, 'h00A);
        cycle();
        check("basic_valid", {31'd0, out_valid}, 32'd1);
        check("basic_res", {24'd0, res}, 32'd90);
        check("basic_err", {31'd0, err}, 32'd0);
        in_valid = 1'b0;
        cycle();

        // Error cases streamed back to back.
        drive(250, 'h10A);
        cycle();
        check("wrap_res", {24'd0, res}, 32'd4);
        check("wrap_err", {31'd0, err}, 32'd1);
        drive(5, 'h00A);
        cycle();
        check("under_res", {24'd0, res}, 32'd251);
        check("under_err", {31'd0, err}, 32'd1);
        drive(7, 'h100);
        cycle();
        check("negzero_res", {24'd0, res}, 32'd7);
        check("negzero_err", {31'd0, err}, 32'd1);
        in_valid = 1'b0;
        cycle();

        // Backpressure: third item held off until the FIFO drains.
        out_ready = 1'b0;
        drive(1, 'h001);
        cycle();
        drive(2, 'h101);
        cycle();
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(3, 'h000);
        cycle();
        cycle();
        check("full_hold_res", {24'd0, res}, 32'd0);
        out_ready = 1'b1;
        cycle();
        check("bp_second_res", {24'd0, res}, 32'd3);
        cycle();
        in_valid = 1'b0;
        check("bp_third_res", {24'd0, res}, 32'd3);
        cycle();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Full-throughput streaming at count 1.
        drive($urandom_range(0, 255), $urandom_range(0, 511));
        cycle();
        for (int i = 0; i < 20; i++) begin
            drive($urandom_range(0, 255), $urandom_range(0, 511));
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_ready", {31'd0, in_ready}, 32'd1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();

        // Mid-operation reset with two items buffered.
        out_ready = 1'b0;
        drive(10, 'h003);
        cycle();
        drive(20, 'h104);
        cycle();
        in_valid = 1'b0;
        pulse_reset();
        out_ready = 1'b1;
        repeat (3) cycle();

        // Randomized consistent codes with random handshakes.
        rnd_mode = 1'b1;
        n_acc = 0;
        n_del = 0;
        for (int n = 0; n < 20000 && n_del < 1000; n++) begin
            if (n_acc < 1000 && $urandom_range(0, 3) != 0) begin
                int a;
                a = $urandom_range(0, 255);
                cur_b = $urandom_range(0, 255);
                drive(a, (cur_b > a) ? (256 + cur_b - a) : (a - cur_b));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid = 1'b0;
        check("rnd_delivered", n_del, 32'd1000);
        check("rnd_sample_cnt", {16'd0, sample_cnt}, STATS ? 32'd1000 : 32'd0);
        check("rnd_err_cnt", {16'd0, err_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abs_diff_recon.md
ABS_DIFF_RECON -- requirements
Module: abs_diff_recon

Interface
REQ-001 Parameter INPUT_WIDTH, default 8, operand width W.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream item present.
REQ-005 in_ready  output  1  block can accept an item this cycle.
REQ-006 in_0  input  W  reference operand a.
REQ-007 in_1  input  W+1  abs_diff code: bit W = sign (1: b > a), bits W-1:0 = |a-b|.
REQ-008 out_valid  output  1  reconstructed item present.
REQ-009 out_ready  input  1  downstream accepts item.
REQ-010 res  output  W  reconstructed operand b.
REQ-011 err  output  1  item's code was inconsistent with a.
REQ-012 sample_cnt  output  16  count of delivered items (stats option).
REQ-013 err_cnt  output  16  count of delivered items with err=1 (stats option).

Function
REQ-014 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-015 Decode SHALL be: sign=0 -> b=a-mag; sign=1 -> b=a+mag; result taken modulo 2^W.
REQ-016 err SHALL be 1 when sign=0 and mag>a, when sign=1 and a+mag>2^W-1, or when sign=1 and mag=0; otherwise 0.
REQ-017 Decoded {res,err} SHALL be written into a 2-entry FIFO on the input-transfer edge; out_valid SHALL assert the following cycle (latency 1).
REQ-018 in_ready SHALL equal (FIFO count < 2), depending on registered state only, never combinationally on out_ready or in_valid.
REQ-019 Simultaneous push and pop SHALL keep the count unchanged and preserve order; at count 2 no push occurs even if out_ready=1 that cycle.
REQ-020 out_valid SHALL equal (count > 0); res/err SHALL show the FIFO head and stay stable while out_valid=1 and out_ready=0.
REQ-021 Items SHALL be delivered in acceptance order, none lost or duplicated.
REQ-022 Read/write pointers SHALL wrap modulo 2.

Reset
REQ-023 While rst_n=0: count=0, pointers=0, in_ready=0? No -- in_ready SHALL be 1, out_valid=0, res=0, err=0, sample_cnt=0, err_cnt=0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered items immediately, with no output transfer completing on the edge where rst_n is low.
REQ-025 First transfer after release SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro ABS_DIFF_RECON_STATS_EN defined: sample_cnt SHALL increment on each output transfer and err_cnt on each output transfer with err=1, both saturating at 16'hFFFF.
REQ-027 Macro not defined: sample_cnt and err_cnt SHALL be constant 0 with no counter registers; all other behaviour identical.

Verification
REQ-028 a=8'd100, code=9'h00A, out_ready=1 -> next cycle res=8'd90, err=0.
REQ-029 a=8'd250, code=9'h10A -> res=8'd4 (wrap), err=1; a=8'd5, code=9'h00A -> res=8'd251, err=1; a=8'd7, code=9'h100 -> res=8'd7, err=1.
REQ-030 out_ready=0, push items a=1/code=9'h001, a=2/code=9'h101, a=3/code=9'h000 -> first two accepted, in_ready=0 from the cycle after the second; raising out_ready yields res=0,3 in order, then the third item (res=3) is accepted and delivered.
REQ-031 in_valid=1 and out_ready=1 held every cycle with count=1 -> one item in and one out per cycle, count stays 1, no gaps.
REQ-032 Two items buffered, rst_n pulsed low for half a cycle -> out_valid=0 and counters=0 immediately, no stale item delivered afterwards.
REQ-033 With ABS_DIFF_RECON_STATS_EN, 1000 pseudo-random consistent codes (b from seed-incremented $urandom) -> every res equals the original b, err_cnt=0 and sample_cnt=1000; without the macro, both counters read 0.
